// File: rtl/rggen_register_access_master.sv
// rggen_register_access_master
//   Initiator for the register bus. A command accepted on the cmd channel
//   becomes one register access (valid/access/address/write_data/strobe).
//   The access is held until the register side answers, and the answer is
//   returned on the rsp channel. At most one access is outstanding.
//
// Parameters
//   ADDRESS_WIDTH  : command / register address width
//   BUS_WIDTH      : data width; the strobe is a bit-level mask of this width
//   TIMEOUT_CYCLES : ACCESS cycles before forced error completion (2..65535),
//                    only used when RGGEN_ACCESS_MASTER_TIMEOUT_EN is defined
//
// Optional feature
//   `define RGGEN_ACCESS_MASTER_TIMEOUT_EN : bound each access to
//   TIMEOUT_CYCLES cycles; otherwise ACCESS waits for ready indefinitely.
//
// Ports
//   i_clk, i_rst_n                      : clock, async active-low reset
//   i_cmd_* / o_cmd_ready               : command channel (valid/ready)
//   o_rsp_* / i_rsp_ready               : response channel (valid/ready)
//   o_register_*                        : access driven to the register blocks
//   i_register_active/ready/status/read_data : register-side answer
module rggen_register_access_master #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic                     i_cmd_posted,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH-1:0]     i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH-1:0]     o_register_strobe,
  input  logic                     i_register_active,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;

  logic [1:0] state;
  logic       cmd_accept;
  logic       timeout_hit;
  logic       access_done;
  logic       access_error;

  assign cmd_accept = (state == IDLE) && i_cmd_valid && o_cmd_ready;

`ifdef RGGEN_ACCESS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timeout_count;

  // Cleared on entry to ACCESS, so the count equals the number of ACCESS
  // cycles already spent without completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_count <= '0;
    end else if (cmd_accept) begin
      timeout_count <= '0;
    end else if (state == ACCESS) begin
      timeout_count <= timeout_count + 16'd1;
    end
  end

  assign timeout_hit = (state == ACCESS) && (timeout_count == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // A dropped active line beats ready; ready beats the timeout.
  always_comb begin
    access_done  = !i_register_active || i_register_ready || timeout_hit;
    access_error = !i_register_active || (!i_register_ready && timeout_hit);
  end

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the pre-edge values; blocking here would chain updates
  // within one edge and diverge from the synthesized flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      o_cmd_ready           <= 1'b0;
      o_rsp_valid           <= 1'b0;
      o_rsp_read_data       <= '0;
      o_rsp_status          <= '0;
      o_register_valid      <= 1'b0;
      o_register_access     <= '0;
      o_register_address    <= '0;
      o_register_write_data <= '0;
      o_register_strobe     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            o_cmd_ready           <= 1'b0;
            o_register_valid      <= 1'b1;
            // bit0 = write, bit1 = non-posted; posted is meaningless on reads.
            o_register_access     <= i_cmd_write ? {~i_cmd_posted, 1'b1} : 2'b10;
            o_register_address    <= i_cmd_address;
            o_register_write_data <= i_cmd_write_data;
            o_register_strobe     <= i_cmd_strobe;
            state                 <= ACCESS;
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end
        ACCESS: begin
          if (access_done) begin
            o_register_valid <= 1'b0;
            o_rsp_valid      <= 1'b1;
            o_rsp_status     <= access_error ? STATUS_SLAVE_ERROR : i_register_status;
            o_rsp_read_data  <= (access_error || o_register_access[0])
                                ? '0 : i_register_read_data;
            state            <= RESPOND;
          end
        end
        RESPOND: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_register_access_master.sv
// tb_rggen_register_access_master
//   Randomized bench for rggen_register_access_master. A command driver
//   issues transactions and pushes the slave plan plus the predicted response
//   into queues. A slave model answers accesses per plan and checks the
//   driven access; a response monitor compares each response, its latency
//   and its stability against the prediction. Define
//   RGGEN_ACCESS_MASTER_TIMEOUT_EN to exercise the timeout with
//   TIMEOUT_CYCLES = 4.
module tb_rggen_register_access_master;

  localparam int AW      = 8;
  localparam int BW      = 32;
  localparam int TO      = 4;
  localparam int NUM_TXN = 60;

  typedef struct {
    bit          write;
    bit          posted;
    bit [AW-1:0] addr;
    bit [BW-1:0] wdata;
    bit [BW-1:0] strobe;
    bit [BW-1:0] rdata;
    int          w;       // ACCESS cycles of wait before the slave answers
    bit          drop;    // slave answers with active=0 instead of ready
    bit [1:0]    status;
  } txn_t;

  typedef struct {
    bit [BW-1:0] rdata;
    bit [1:0]    status;
    longint      cyc;     // cycle count at which rsp_valid must first appear
  } rsp_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_write = 1'b0;
  logic          i_cmd_posted = 1'b0;
  logic [AW-1:0] i_cmd_address = '0;
  logic [BW-1:0] i_cmd_write_data = '0;
  logic [BW-1:0] i_cmd_strobe = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [BW-1:0] o_rsp_read_data;
  logic [1:0]    o_rsp_status;
  logic          o_register_valid;
  logic [1:0]    o_register_access;
  logic [AW-1:0] o_register_address;
  logic [BW-1:0] o_register_write_data;
  logic [BW-1:0] o_register_strobe;
  logic          i_register_active = 1'b1;
  logic          i_register_ready = 1'b0;
  logic [1:0]    i_register_status = '0;
  logic [BW-1:0] i_register_read_data = '0;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     start = 1'b0;
  txn_t   plan_q[$];
  rsp_t   rsp_q[$];

  rggen_register_access_master #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_cmd_valid          (i_cmd_valid),
    .o_cmd_ready          (o_cmd_ready),
    .i_cmd_write          (i_cmd_write),
    .i_cmd_posted         (i_cmd_posted),
    .i_cmd_address        (i_cmd_address),
    .i_cmd_write_data     (i_cmd_write_data),
    .i_cmd_strobe         (i_cmd_strobe),
    .o_rsp_valid          (o_rsp_valid),
    .i_rsp_ready          (i_rsp_ready),
    .o_rsp_read_data      (o_rsp_read_data),
    .o_rsp_status         (o_rsp_status),
    .o_register_valid     (o_register_valid),
    .o_register_access    (o_register_access),
    .o_register_address   (o_register_address),
    .o_register_write_data(o_register_write_data),
    .o_register_strobe    (o_register_strobe),
    .i_register_active    (i_register_active),
    .i_register_ready     (i_register_ready),
    .i_register_status    (i_register_status),
    .i_register_read_data (i_register_read_data)
  );

  always #5 i_clk = ~i_clk;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Index (0-based) of the ACCESS cycle in which the access completes.
  function automatic int done_index(input txn_t t);
`ifdef RGGEN_ACCESS_MASTER_TIMEOUT_EN
    return (t.w < TO - 1) ? t.w : TO - 1;
`else
    return t.w;
`endif
  endfunction

  function automatic bit is_error(input txn_t t);
`ifdef RGGEN_ACCESS_MASTER_TIMEOUT_EN
    return t.drop || (t.w > TO - 1);
`else
    return t.drop;
`endif
  endfunction

  function automatic bit [1:0] exp_access(input txn_t t);
    if (!t.write)     return 2'b10;
    else if (t.posted) return 2'b01;
    else               return 2'b11;
  endfunction

  function automatic rsp_t predict(input txn_t t, input longint accept_cyc);
    rsp_t r;
    r.status = is_error(t) ? 2'b10 : t.status;
    r.rdata  = (is_error(t) || t.write) ? '0 : t.rdata;
    // One cycle to enter ACCESS, done_index waits, one cycle to register rsp.
    r.cyc    = accept_cyc + 2 + done_index(t);
    return r;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.write  = 1'($urandom_range(0, 1));
    t.posted = 1'($urandom_range(0, 1));
    t.addr   = AW'($urandom);
    t.wdata  = $urandom;
    t.strobe = $urandom;
    t.rdata  = $urandom;
    t.w      = int'($urandom_range(0, 5));
    t.drop   = ($urandom_range(0, 5) == 0);
    t.status = 2'($urandom_range(0, 2));
    return t;
  endfunction

  function automatic txn_t directed_txn(input int i);
    txn_t t;
    t = rand_txn();
    case (i)
      0: begin t.write = 0; t.addr = 8'h10; t.strobe = 32'hFFFF_FFFF; t.w = 0;
               t.drop = 0; t.rdata = 32'hA5A5_0001; t.status = 2'b00; end
      1: begin t.write = 1; t.posted = 0; t.addr = 8'h04; t.wdata = 32'hDEAD_BEEF;
               t.strobe = 32'h0000_FFFF; t.w = 3; t.drop = 0; t.status = 2'b00; end
      2: begin t.write = 1; t.posted = 1; t.w = 0; t.drop = 1; end
      default: begin t.write = 0; t.posted = 1; t.w = 1; t.drop = 0; t.status = 2'b01; end
    endcase
    return t;
  endfunction

  // ---------------- slave model ----------------
  initial begin
    txn_t cur;
    int   k;
    k   = 0;
    cur = rand_txn();
    wait (start);
    forever begin
      @(negedge i_clk);
      if (o_register_valid) begin
        if (k == 0) begin
          check("plan_available", longint'(plan_q.size() > 0), 1);
          if (plan_q.size() > 0) cur = plan_q.pop_front();
        end
        check("reg_access",  o_register_access,     exp_access(cur));
        check("reg_address", o_register_address,    cur.addr);
        check("reg_wdata",   o_register_write_data, cur.wdata);
        check("reg_strobe",  o_register_strobe,     cur.strobe);
        if (k == cur.w && cur.drop) begin
          // Random ready alongside active=0 checks that active wins.
          i_register_active    = 1'b0;
          i_register_ready     = 1'($urandom_range(0, 1));
          i_register_status    = 2'($urandom);
          i_register_read_data = $urandom;
        end else if (k == cur.w) begin
          i_register_active    = 1'b1;
          i_register_ready     = 1'b1;
          i_register_status    = cur.status;
          i_register_read_data = cur.rdata;
        end else begin
          i_register_active    = 1'b1;
          i_register_ready     = 1'b0;
          i_register_status    = 2'($urandom);
          i_register_read_data = $urandom;
        end
        k++;
      end else begin
        if (k > 0) begin
          check("reg_valid_cycles", k, done_index(cur) + 1);
          k = 0;
        end
        // Outside ACCESS the register side is ignored, so drive noise.
        i_register_active    = 1'($urandom_range(0, 1));
        i_register_ready     = 1'($urandom_range(0, 1));
        i_register_status    = 2'($urandom);
        i_register_read_data = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_t e;
    int   held;
    int   target;
    int   rsp_idx;
    bit   hs_prev;
    bit   r;
    held    = 0;
    rsp_idx = 0;
    hs_prev = 0;
    target  = 0;
    wait (start);
    forever begin
      @(negedge i_clk);
      if (hs_prev) begin
        check("cmd_ready_after_hs", o_cmd_ready, 1);
        check("rsp_valid_after_hs", o_rsp_valid, 0);
        hs_prev = 0;
      end
      r = 1'($urandom_range(0, 1));
      if (o_rsp_valid) begin
        check("rsp_expected", longint'(rsp_q.size() > 0), 1);
        if (rsp_q.size() > 0) begin
          e = rsp_q[0];
          if (held == 0) begin
            target = (rsp_idx == 3) ? 5 : int'($urandom_range(0, 2));
            check("rsp_latency", cyc, e.cyc);
          end
          check("rsp_read_data",      o_rsp_read_data, e.rdata);
          check("rsp_status",         o_rsp_status,    e.status);
          check("cmd_ready_in_rsp",   o_cmd_ready,     0);
          check("reg_valid_in_rsp",   o_register_valid, 0);
          r = (held >= target);
          held++;
          if (r) begin
            void'(rsp_q.pop_front());
            held    = 0;
            hs_prev = 1;
            rsp_idx++;
          end
        end
      end
      i_rsp_ready = r;
    end
  end

  // ---------------- reset checks and command driver ----------------
  initial begin
    txn_t t;
    int   wait_cnt;
    int   gap;

    #2;
    check("rst_cmd_ready",  o_cmd_ready,        0);
    check("rst_rsp_valid",  o_rsp_valid,        0);
    check("rst_reg_valid",  o_register_valid,   0);
    check("rst_reg_access", o_register_access,  0);
    check("rst_reg_addr",   o_register_address, 0);
    check("rst_rsp_status", o_rsp_status,       0);
    check("rst_rsp_data",   o_rsp_read_data,    0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    check("cmd_ready_held_at_release", o_cmd_ready, 0);
    @(negedge i_clk);
    check("cmd_ready_after_release", o_cmd_ready, 1);

    // Start an access the slave never answers, then reset in the middle.
    i_cmd_valid   = 1'b1;
    i_cmd_write   = 1'b0;
    i_cmd_address = 8'h33;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    check("mid_reg_valid", o_register_valid, 1);
    check("mid_cmd_ready", o_cmd_ready,      0);
    @(negedge i_clk);
    check("mid_reg_valid_hold", o_register_valid, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_reg_valid", o_register_valid, 0);
    check("async_rst_rsp_valid", o_rsp_valid,      0);
    check("async_rst_cmd_ready", o_cmd_ready,      0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("cmd_ready_after_rerelease", o_cmd_ready, 1);
    check("no_rsp_after_reset",        o_rsp_valid, 0);
    start = 1'b1;

    for (int i = 0; i < NUM_TXN; i++) begin
      t   = (i < 4) ? directed_txn(i) : rand_txn();
      gap = (i == 4) ? 0 : int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge i_clk);
        i_cmd_valid      = 1'b0;
        i_cmd_write      = 1'($urandom_range(0, 1));
        i_cmd_address    = AW'($urandom);
        i_cmd_write_data = $urandom;
      end
      @(negedge i_clk);
      i_cmd_valid      = 1'b1;
      i_cmd_write      = t.write;
      i_cmd_posted     = t.posted;
      i_cmd_address    = t.addr;
      i_cmd_write_data = t.wdata;
      i_cmd_strobe     = t.strobe;
      wait_cnt = 0;
      while (!o_cmd_ready && wait_cnt < 200) begin
        @(negedge i_clk);
        wait_cnt++;
      end
      check("cmd_accepted_in_time", longint'(wait_cnt < 200), 1);
      if (wait_cnt >= 200) break;
      // o_cmd_ready is high with valid, so the coming edge accepts.
      plan_q.push_back(t);
      rsp_q.push_back(predict(t, cyc));
    end
    @(negedge i_clk);
    i_cmd_valid = 1'b0;

    wait_cnt = 0;
    while ((rsp_q.size() > 0 || plan_q.size() > 0) && wait_cnt < 500) begin
      @(negedge i_clk);
      wait_cnt++;
    end
    check("drain_rsp",  rsp_q.size(),  0);
    check("drain_plan", plan_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
